example: RTL and testbench

Dispatch-tracking block for the processor core: holds up to ENTRIES in-flight operations, each with a dependency bit mask. Entries clear dependency bits on wakeup broadcasts and raise a per-entry issue request once all dependencies are satisfied. A granted request frees its entry. The block sits between dispatch and the functional-unit select logic.

---
 rtl/example.sv | 67 ++++++
 tb/tb_example.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/example.sv
// rtl/example.sv - dispatch tracker: per-entry dependency masks, wakeup clearing, issue requests
module example #(
  parameter int ENTRIES = 4,
  parameter int DEP_W   = 8,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               disp_valid,
  input  logic [DEP_W-1:0]   dep_mask,
  input  logic [DEP_W-1:0]   wakeup,
  input  logic [ENTRIES-1:0] grant,
  output logic [IDX_W-1:0]   free_entry_out,
  output logic               full_out,
  output logic [ENTRIES-1:0] reqs
);

  logic [ENTRIES-1:0] entry_valid;
  logic [DEP_W-1:0]   r_dep [ENTRIES];

  logic [IDX_W-1:0]   w_free;
  logic               w_full;
  logic [ENTRIES-1:0] w_reqs;
  logic               w_disp_ok;

  // Scan downward so the lowest invalid index wins; 0 when nothing is free.
  always_comb begin
    w_free = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!entry_valid[i]) w_free = IDX_W'(i);
    end
  end

  always_comb begin
    w_reqs = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_reqs[i] = entry_valid[i] && (r_dep[i] == '0);
    end
  end

  assign w_full         = &entry_valid;
  assign w_disp_ok      = disp_valid && !w_full;
  assign free_entry_out = w_free;
  assign full_out       = w_full;
  assign reqs           = w_reqs;

  // The free slot is invalid pre-edge, so it can never also be a granted entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_dep[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (grant[i] && w_reqs[i]) begin
          entry_valid[i] <= 1'b0;
          r_dep[i]       <= '0;
        end else if (w_disp_ok && (w_free == IDX_W'(i))) begin
          entry_valid[i] <= 1'b1;
          r_dep[i]       <= dep_mask & ~wakeup;
        end else if (entry_valid[i]) begin
          r_dep[i]       <= r_dep[i] & ~wakeup;
        end
      end
    end
  end

endmodule

// File: tb/tb_example.sv
// tb/tb_example.sv - randomized self-checking bench for the dispatch tracker
module tb_example;
  localparam int E = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         disp_valid;
  logic [D-1:0] dep_mask;
  logic [D-1:0] wakeup;
  logic [E-1:0] grant;
  logic [1:0]   free_entry_out;
  logic         full_out;
  logic [E-1:0] reqs;

  int checks = 0;
  int failures = 0;

  bit           m_valid [E];
  logic [D-1:0] m_dep   [E];

  example #(.ENTRIES(E), .DEP_W(D)) dut (
    .clk(clk), .rst(rst), .disp_valid(disp_valid), .dep_mask(dep_mask),
    .wakeup(wakeup), .grant(grant), .free_entry_out(free_entry_out),
    .full_out(full_out), .reqs(reqs)
  );

  always #5 clk = ~clk;

  function automatic logic [E-1:0] m_reqs();
    logic [E-1:0] r = '0;
    for (int i = 0; i < E; i++) r[i] = m_valid[i] && (m_dep[i] == 0);
    return r;
  endfunction

  function automatic logic [E-1:0] m_vec();
    logic [E-1:0] v = '0;
    for (int i = 0; i < E; i++) v[i] = m_valid[i];
    return v;
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < E; i++) if (!m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [1:0] m_free();
    for (int i = 0; i < E; i++) if (!m_valid[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < E; i++) begin
      m_valid[i] = 1'b0;
      m_dep[i]   = '0;
    end
  endtask

  task automatic drive(input bit dv, input logic [D-1:0] dm, input logic [D-1:0] wk, input logic [E-1:0] gr);
    disp_valid = dv;
    dep_mask   = dm;
    wakeup     = wk;
    grant      = gr;
  endtask

  // Advance one clock: reference state follows the behavioural rules using pre-edge values.
  task automatic tick();
    bit           full_pre;
    logic [1:0]   free_pre;
    logic [E-1:0] req_pre;
    full_pre = m_full();
    free_pre = m_free();
    req_pre  = m_reqs();
    @(posedge clk);
    #1;
    for (int i = 0; i < E; i++) begin
      if (grant[i] && req_pre[i]) begin
        m_valid[i] = 1'b0;
        m_dep[i]   = '0;
      end else if (m_valid[i]) begin
        m_dep[i] = m_dep[i] & ~wakeup;
      end
    end
    if (rst && disp_valid && !full_pre) begin
      m_valid[free_pre] = 1'b1;
      m_dep[free_pre]   = dep_mask & ~wakeup;
    end
    if (!rst) m_clear();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_clear();
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0);
    rst = 1'b0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dut.entry_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=%b", dut.entry_valid, 4'b0000); end
    checks++; if (reqs !== 4'b0000) begin failures++; $display("FAIL reset_reqs got=%b exp=%b", reqs, 4'b0000); end
    checks++; if (full_out !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full_out); end
    checks++; if (free_entry_out !== 2'd0) begin failures++; $display("FAIL reset_free got=%0d exp=0", free_entry_out); end
    rst = 1'b1;
  endtask

  task automatic test_dispatch_ready();
    do_reset();
    drive(1, 8'h00, 0, 0); tick(); drive(0, 0, 0, 0);
    checks++; if (dut.entry_valid !== 4'b0001) begin failures++; $display("FAIL disp_valid_vec got=%b exp=0001", dut.entry_valid); end
    checks++; if (reqs !== 4'b0001) begin failures++; $display("FAIL disp_reqs got=%b exp=0001", reqs); end
    checks++; if (free_entry_out !== 2'd1) begin failures++; $display("FAIL disp_free got=%0d exp=1", free_entry_out); end
    checks++; if (full_out !== 1'b0) begin failures++; $display("FAIL disp_full got=%b exp=0", full_out); end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1, 8'h01, 0, 0); tick();
    end
    drive(0, 0, 0, 0);
    checks++; if (dut.entry_valid !== 4'b1111) begin failures++; $display("FAIL full_vec got=%b exp=1111", dut.entry_valid); end
    checks++; if (full_out !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", full_out); end
    checks++; if (reqs !== 4'b0000) begin failures++; $display("FAIL full_reqs got=%b exp=0000", reqs); end
    drive(1, 8'h00, 0, 0); tick(); drive(0, 0, 0, 0);
    checks++; if (dut.entry_valid !== 4'b1111 || reqs !== 4'b0000) begin failures++; $display("FAIL full_drop got=%b/%b exp=1111/0000", dut.entry_valid, reqs); end
    checks++; if (free_entry_out !== 2'd0) begin failures++; $display("FAIL full_free got=%0d exp=0", free_entry_out); end
  endtask

  task automatic test_wakeup();
    do_reset();
    drive(1, 8'h06, 0, 0); tick();
    drive(0, 0, 8'h02, 0); tick();
    checks++; if (reqs[0] !== 1'b0) begin failures++; $display("FAIL wake_partial got=%b exp=0", reqs[0]); end
    drive(0, 0, 8'h04, 0); tick(); drive(0, 0, 0, 0);
    checks++; if (reqs !== 4'b0001) begin failures++; $display("FAIL wake_last got=%b exp=0001", reqs); end
  endtask

  task automatic test_same_cycle_wakeup();
    do_reset();
    drive(1, 8'h10, 8'h10, 0); tick(); drive(0, 0, 0, 0);
    checks++; if (reqs !== 4'b0001) begin failures++; $display("FAIL same_wake got=%b exp=0001", reqs); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 8'h01, 0, 0); tick();
    drive(1, 8'h00, 0, 0); tick();
    checks++; if (reqs !== 4'b0010) begin failures++; $display("FAIL b2b_pre got=%b exp=0010", reqs); end
    drive(1, 8'h00, 0, 4'b0010); tick(); drive(0, 0, 0, 0);
    checks++; if (dut.entry_valid !== 4'b0101) begin failures++; $display("FAIL b2b_vec got=%b exp=0101", dut.entry_valid); end
    checks++; if (free_entry_out !== 2'd1) begin failures++; $display("FAIL b2b_free got=%0d exp=1", free_entry_out); end
    checks++; if (reqs !== 4'b0100) begin failures++; $display("FAIL b2b_reqs got=%b exp=0100", reqs); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 8'h00, 0, 0); tick();
    end
    drive(0, 0, 0, 0);
    #3;
    rst = 1'b0;
    #1;
    m_clear();
    checks++; if (dut.entry_valid !== 4'b0000) begin failures++; $display("FAIL async_valid got=%b exp=0000", dut.entry_valid); end
    checks++; if (reqs !== 4'b0000 || full_out !== 1'b0) begin failures++; $display("FAIL async_out got=%b/%b exp=0000/0", reqs, full_out); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1, 8'h01, 0, 0); tick();
    drive(0, 0, 0, 4'b0001); tick(); drive(0, 0, 0, 0);
    checks++; if (dut.entry_valid !== 4'b0001) begin failures++; $display("FAIL grant_ignored got=%b exp=0001", dut.entry_valid); end
  endtask

  task automatic test_random();
    logic [D-1:0] wk;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      wk = D'($urandom) & D'($urandom) & D'($urandom);
      drive(($urandom_range(0, 3) != 0), D'($urandom) & D'($urandom), wk, E'($urandom));
      tick();
      checks++;
      if (dut.entry_valid !== m_vec() || reqs !== m_reqs() || full_out !== m_full() || free_entry_out !== m_free()) begin
        failures++;
        $display("FAIL rand_cycle%0d got=v%b r%b f%b i%0d exp=v%b r%b f%b i%0d", k,
                 dut.entry_valid, reqs, full_out, free_entry_out, m_vec(), m_reqs(), m_full(), m_free());
      end
    end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0);
    rst = 1'b0;
    test_reset();
    test_dispatch_ready();
    test_full();
    test_wakeup();
    test_same_cycle_wakeup();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
